// File: rtl/bfm_ahbl_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one AHB slot, 16 one-hot PSEL lines.
// Define BFM_AHBLAPB_PSLVERR_EN to turn PSLVERR into a two-cycle AHB ERROR response.
//
// state  | meaning
// IDLE   | no transfer pending, zero-wait OKAY
// WAIT   | AHB data phase: HWDATA captured, APB SETUP prepared
// SETUP  | APB SETUP cycle (PSEL=1, PENABLE=0)
// ACCESS | APB ACCESS cycle, held while PREADY=0
// DONE   | transfer complete, OKAY; may accept the next address
// ERR1   | first ERROR cycle (HREADYOUT=0, HRESP=1)
// ERR2   | second ERROR cycle (HREADYOUT=1, HRESP=1), no accept
module bfm_ahbl_apb_bridge #(
  parameter int TPD      = 1,   // output delay belongs to the timed sim view, not modelled here
  parameter int PSEL_LSB = 24
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [15:0] PSEL,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4,
    S_ERR1   = 3'd5,
    S_ERR2   = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic        hreadyout_q, hreadyout_d;
  logic        hresp_q, hresp_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [15:0] psel_q, psel_d;
  logic [31:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic        penable_q, penable_d;
  logic [31:0] pwdata_q, pwdata_d;

  logic        accept;
  logic        apb_err;
  logic [15:0] psel_dec;
  logic        unused_ok;

  assign accept   = HSEL & HREADYIN & HTRANS[1];
  assign psel_dec = 16'h0001 << paddr_q[PSEL_LSB +: 4];

`ifdef BFM_AHBLAPB_PSLVERR_EN
  assign apb_err = PSLVERR;
`else
  assign apb_err = 1'b0;
`endif

  assign unused_ok = ^{TPD, HSIZE, HBURST, HMASTLOCK, HPROT, HTRANS[0], PSLVERR};

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_WAIT;
      S_WAIT:   state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (PREADY) state_d = apb_err ? S_ERR1 : S_DONE;
      S_DONE:   state_d = accept ? S_WAIT : S_IDLE;
      S_ERR1:   state_d = S_ERR2;
      S_ERR2:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so every port comes straight from a flop.
  always_comb begin
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    hrdata_d    = hrdata_q;
    psel_d      = psel_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    penable_d   = penable_q;
    pwdata_d    = pwdata_q;

    case (state_d)
      S_WAIT, S_SETUP, S_ACCESS: hreadyout_d = 1'b0;
      S_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end
      S_ERR2:  hresp_d = 1'b1;
      default: ;
    endcase

    if (((state_q == S_IDLE) || (state_q == S_DONE)) && accept) begin
      paddr_d  = HADDR;
      pwrite_d = HWRITE;
    end

    case (state_q)
      S_WAIT: begin
        pwdata_d  = HWDATA;
        psel_d    = psel_dec;
        penable_d = 1'b0;
      end
      S_SETUP: penable_d = 1'b1;
      S_ACCESS: begin
        if (PREADY) begin
          psel_d    = 16'h0000;
          penable_d = 1'b0;
          if (!pwrite_q) hrdata_d = PRDATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'h0;
      psel_q      <= 16'h0;
      paddr_q     <= 32'h0;
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= 32'h0;
    end else begin
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      psel_q      <= psel_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      penable_q   <= penable_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PSEL      = psel_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PENABLE   = penable_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_bfm_ahbl_apb_bridge.sv
// Scoreboard bench for bfm_ahbl_apb_bridge: random AHB master, reactive APB slave,
// reference memory model; expectations follow BFM_AHBLAPB_PSLVERR_EN when defined.
module tb_bfm_ahbl_apb_bridge;

`ifdef BFM_AHBLAPB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'h0;
  logic        HWRITE = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'd2;
  logic [2:0]  HBURST = 3'd0;
  logic        HMASTLOCK = 1'b0;
  logic [3:0]  HPROT = 4'h0;
  logic [31:0] HWDATA = 32'h0;
  wire         HREADYIN;
  logic        HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic [15:0] PSEL;
  logic [31:0] PADDR, PWDATA;
  logic        PWRITE, PENABLE;
  logic [31:0] PRDATA = 32'h0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  assign HREADYIN = HREADYOUT;

  bfm_ahbl_apb_bridge #(.TPD(1), .PSEL_LSB(24)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic        resp;
    int          waits;
  } ahb_exp_t;

  typedef struct {
    logic [15:0] psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    int          nw;
    logic        er;
  } apb_exp_t;

  ahb_exp_t    ahb_q[$];
  apb_exp_t    apb_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];
  logic [31:0] last_rdata = 32'h0;
  int          prev_ncyc_exp = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hC3A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one NONSEQ transfer; returns once accepted, with HWDATA placed in the data phase.
  task automatic ahb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input int nw, input logic er, output int ncyc);
    ahb_exp_t ae;
    apb_exp_t pe;
    bit       ok;
    ok        = 1'b0;
    ncyc      = 0;
    HSEL      = 1'b1;
    HTRANS    = 2'b10;
    HADDR     = a;
    HWRITE    = wr;
    HSIZE     = 3'($urandom);
    HBURST    = 3'($urandom);
    HPROT     = 4'($urandom);
    HMASTLOCK = 1'($urandom);
    for (int i = 0; i < 64; i++) begin
      @(negedge HCLK);
      ncyc++;
      if (HREADYOUT && !HRESP) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: addr 0x%08h not accepted within 64 cycles", a);
      HTRANS = 2'b00;
      HSEL   = 1'b0;
      return;
    end
    @(posedge HCLK);
    #1;
    HTRANS = 2'b00;
    HSEL   = 1'b0;
    HWDATA = wd;

    pe.psel   = 16'(32'd1 << ((a >> 24) & 32'd15));
    pe.paddr  = a;
    pe.pwrite = wr;
    pe.pwdata = wd;
    pe.nw     = nw;
    pe.er     = er;
    apb_q.push_back(pe);

    if (wr) ref_mem[a] = wd;
    else last_rdata = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    ae.wr    = wr;
    ae.rdata = last_rdata;
    ae.resp  = ERR_EN && er;
    ae.waits = 3 + nw + ((ERR_EN && er) ? 1 : 0);
    ahb_q.push_back(ae);
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input int nw, input logic er, input bit b2b);
    int n;
    ahb_xfer(wr, a, wd, nw, er, n);
    if (b2b) check("b2b_accept_cycles", n, prev_ncyc_exp);
    prev_ncyc_exp = 4 + nw + ((ERR_EN && er) ? 2 : 0);
  endtask

  // AHB monitor: counts wait states of each data phase and checks the completing response.
  bit       in_dp = 1'b0;
  int       mon_waits = 0;
  logic     low_resp = 1'b0;
  ahb_exp_t mon_ae;

  always @(negedge HCLK) begin
    if (!HRESETN) begin
      in_dp = 1'b0;
    end else begin
      if (in_dp) begin
        if (!HREADYOUT) begin
          mon_waits++;
          low_resp = HRESP;
        end else begin
          in_dp = 1'b0;
          if (ahb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL ahb_unexpected_completion at %0t", $time);
          end else begin
            mon_ae = ahb_q.pop_front();
            check("ahb_wait_states", mon_waits, mon_ae.waits);
            check("ahb_hresp", HRESP, mon_ae.resp);
            check("ahb_hrdata", HRDATA, mon_ae.rdata);
            check("ahb_last_wait_hresp", low_resp, mon_ae.resp);
          end
        end
      end else begin
        check("idle_okay_apb_quiet", {13'h0, HREADYOUT, HRESP, PENABLE, PSEL}, 32'h0004_0000);
      end
      if (HSEL && HTRANS[1] && HREADYOUT && !HRESP) begin
        in_dp     = 1'b1;
        mon_waits = 0;
        low_resp  = 1'b0;
      end
    end
  end

  // APB slave + monitor: wait states and PSLVERR come from the scoreboard entry.
  int          phase = 0;
  int          acc_cnt = 0;
  apb_exp_t    cur;
  logic [31:0] slv_a;

  always @(negedge HCLK) begin
    if (!HRESETN) begin
      phase   = 0;
      acc_cnt = 0;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = $urandom;
      if (phase == 2) begin
        phase = 0;
        check("apb_hold_paddr", PADDR, cur.paddr);
        check("apb_hold_pwrite", PWRITE, cur.pwrite);
        check("apb_hold_pwdata", PWDATA, cur.pwdata);
      end
      if (PSEL != 16'h0 && !PENABLE) begin
        if (phase != 0 || apb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL apb_setup_unexpected: PSEL 0x%04h phase %0d", PSEL, phase);
        end else begin
          cur = apb_q.pop_front();
          check("apb_psel", PSEL, cur.psel);
          check("apb_paddr", PADDR, cur.paddr);
          check("apb_pwrite", PWRITE, cur.pwrite);
          check("apb_pwdata", PWDATA, cur.pwdata);
          phase   = 1;
          acc_cnt = 0;
        end
      end else if (PSEL != 16'h0 && PENABLE) begin
        if (phase != 1) begin
          tests++;
          fails++;
          $display("FAIL apb_access_without_setup: PSEL 0x%04h", PSEL);
        end else if (acc_cnt < cur.nw) begin
          acc_cnt++;
        end else begin
          PREADY  = 1'b1;
          PSLVERR = cur.er;
          slv_a   = PADDR;
          if (PWRITE) slv_mem[slv_a] = PWDATA;
          else PRDATA = slv_mem.exists(slv_a) ? slv_mem[slv_a] : init_val(slv_a);
          phase = 2;
        end
      end else if (PENABLE) begin
        tests++;
        fails++;
        $display("FAIL apb_penable_without_psel at %0t", $time);
      end
    end
  end

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [31:0] a;
    int          nw, gap, kind;
    logic        wr, er;
    bit          ok;

    #2 HRESETN = 1'b0;
    #1;
    check("rst_hreadyout", HREADYOUT, 1);
    check("rst_hresp", HRESP, 0);
    check("rst_hrdata", HRDATA, 0);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    repeat (3) @(posedge HCLK);
    #1 HRESETN = 1'b1;
    @(posedge HCLK);
    #1;

    xfer(1'b1, 32'h0300_0010, 32'hA5A5_1234, 0, 1'b0, 1'b0);
    xfer(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 1'b0, 1'b1);
    xfer(1'b0, 32'h0000_0004, $urandom, 2, 1'b0, 1'b1);
    xfer(1'b0, 32'h0700_0020, $urandom, 1, 1'b1, 1'b1);
    xfer(1'b1, 32'h0700_0024, $urandom, 0, 1'b0, 1'b1);
    xfer(1'b0, 32'h0100_0000, $urandom, 0, 1'b0, 1'b1);
    xfer(1'b0, 32'h0200_0004, $urandom, 0, 1'b0, 1'b1);

    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge HCLK);
      if (ahb_q.size() == 0 && !in_dp) begin
        ok = 1'b1;
        break;
      end
    end
    check("directed_drained", ok, 1);
    HSEL   = 1'b1;
    HTRANS = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      check("idle_xfer_resp", {HREADYOUT, HRESP}, 2'b10);
      check("idle_xfer_psel", PSEL, 0);
    end
    @(posedge HCLK);
    #1;
    HSEL = 1'b0;

    for (int t = 0; t < 150; t++) begin
      wr  = 1'($urandom);
      a   = (($urandom & 32'd1) << 28) | (($urandom % 16) << 24) | (($urandom % 8) << 2);
      nw  = $urandom_range(0, 3);
      er  = ($urandom % 4) == 0;
      gap = (($urandom % 2) == 0 || t == 0) ? $urandom_range(6, 12) : 0;
      for (int g = 0; g < gap; g++) begin
        kind = $urandom % 3;
        HSEL   = (kind != 0);
        HTRANS = (kind == 0) ? 2'b10 : ((kind == 1) ? 2'b00 : 2'b01);
        @(posedge HCLK);
        #1;
      end
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      xfer(wr, a, $urandom, nw, er, gap == 0);
    end

    xfer(1'b0, 32'h0500_0008, $urandom, 8, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      if (PENABLE) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_reached_access", ok, 1);
    #2 HRESETN = 1'b0;
    #1;
    check("midrst_psel", PSEL, 0);
    check("midrst_penable", PENABLE, 0);
    check("midrst_hreadyout", HREADYOUT, 1);
    check("midrst_hresp", HRESP, 0);
    check("midrst_hrdata", HRDATA, 0);
    ahb_q.delete();
    apb_q.delete();
    last_rdata = 32'h0;
    repeat (2) @(posedge HCLK);
    #1 HRESETN = 1'b1;
    @(posedge HCLK);
    #1;
    xfer(1'b0, 32'h0300_0010, $urandom, 1, 1'b0, 1'b0);
    xfer(1'b1, 32'h0F00_0018, 32'h1357_9BDF, 0, 1'b0, 1'b1);
    xfer(1'b0, 32'h0F00_0018, $urandom, 0, 1'b0, 1'b1);

    for (int i = 0; i < 100; i++) begin
      @(negedge HCLK);
      if (ahb_q.size() == 0 && apb_q.size() == 0 && !in_dp) break;
    end
    check("final_ahb_queue_empty", ahb_q.size(), 0);
    check("final_apb_queue_empty", apb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
